// File: rtl/tt_ovi_issue_ctrl.sv
// OVI issue-side controller: credit release/return, in-order sb_id tracking between
// pipeline accept and commit, intake throttling and sticky protocol error flags.
module tt_ovi_issue_ctrl #(
    parameter int unsigned CREDITS  = 16,
    parameter int unsigned INFLIGHT = 8,
    parameter int unsigned SBID_W   = 5,
    localparam int unsigned CNT_W   = $clog2(INFLIGHT + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_issue_valid,
    output logic              o_issue_credit,
    input  logic              i_inq_pop,
    input  logic [SBID_W-1:0] i_inq_sb_id,
    output logic              o_inq_pop_en,
    input  logic              i_commit_valid,
    output logic              o_completed_valid,
    output logic [SBID_W-1:0] o_completed_sb_id,
    output logic [CNT_W-1:0]  o_inflight_cnt,
    output logic              o_credit_err,
    output logic              o_track_err
);

    localparam int unsigned PTR_W  = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Credit FSM state
    logic              state_q, state_d;
    logic [CRED_W-1:0] init_cnt_q, init_cnt_d;
    logic [CRED_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CRED_W-1:0] core_cred_q, core_cred_d;
    logic              credit_q, credit_d;
    logic              ret_dec;
    logic              credit_err_q, credit_err_set;
    logic              issue_take;

    // Tracker state
    logic [SBID_W-1:0] trk_mem [INFLIGHT];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              trk_full, trk_empty;
    logic              push_ok, pop_ok;
    logic              track_err_q, track_err_set;
    logic              cmpl_valid_q;
    logic [SBID_W-1:0] cmpl_sb_id_q, cmpl_sb_id_d;

    // Credit release and return
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        credit_d   = 1'b0;
        ret_dec    = 1'b0;
        if (state_q == ST_INIT) begin
            credit_d   = 1'b1;
            init_cnt_d = init_cnt_q + CRED_W'(1);
            if (init_cnt_q == CRED_W'(CREDITS - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            credit_d = (ret_cnt_q != '0);
            ret_dec  = credit_d;
        end
        // Pops during INIT accumulate here and drain once RUN starts.
        ret_cnt_d = ret_cnt_q + CRED_W'(i_inq_pop) - CRED_W'(ret_dec);
    end

    // Core-held credits: a pulse visible this cycle already belongs to the core.
    always_comb begin
        credit_err_set = i_issue_valid && (core_cred_q == '0) && !credit_q;
        issue_take     = i_issue_valid && !credit_err_set;
        core_cred_d    = core_cred_q + CRED_W'(credit_q) - CRED_W'(issue_take);
    end

    // Tracker bookkeeping
    always_comb begin
        trk_full      = (count_q == CNT_W'(INFLIGHT));
        trk_empty     = (count_q == '0);
        push_ok       = i_inq_pop && !trk_full;
        pop_ok        = i_commit_valid && !trk_empty;
        track_err_set = (i_inq_pop && trk_full) || (i_commit_valid && trk_empty);
        wptr_d        = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d        = pop_ok ? rptr_q + PTR_W'(1) : rptr_q;
        count_d       = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        cmpl_sb_id_d  = pop_ok ? trk_mem[rptr_q] : cmpl_sb_id_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            ret_cnt_q    <= '0;
            core_cred_q  <= '0;
            credit_q     <= 1'b0;
            credit_err_q <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            track_err_q  <= 1'b0;
            cmpl_valid_q <= 1'b0;
            cmpl_sb_id_q <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            core_cred_q  <= core_cred_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_q | credit_err_set;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            track_err_q  <= track_err_q | track_err_set;
            cmpl_valid_q <= pop_ok;
            cmpl_sb_id_q <= cmpl_sb_id_d;
        end
    end

    // Entry storage needs no reset: reads are gated by count.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            trk_mem[wptr_q] <= i_inq_sb_id;
        end
    end

    assign o_issue_credit    = credit_q;
    assign o_inq_pop_en      = !trk_full;
    assign o_completed_valid = cmpl_valid_q;
    assign o_completed_sb_id = cmpl_sb_id_q;
    assign o_inflight_cnt    = count_q;
    assign o_credit_err      = credit_err_q;
    assign o_track_err       = track_err_q;

endmodule

// File: tb/tb_tt_ovi_issue_ctrl.sv
// Directed bench for tt_ovi_issue_ctrl: credit release/return, tracker order, full/empty
// protection, wrap-around and mid-operation reset.
module tb_tt_ovi_issue_ctrl;

    localparam int CNT_W = 4;

    logic             i_clk;
    logic             i_reset;
    logic             i_issue_valid;
    logic             o_issue_credit;
    logic             i_inq_pop;
    logic [4:0]       i_inq_sb_id;
    logic             o_inq_pop_en;
    logic             i_commit_valid;
    logic             o_completed_valid;
    logic [4:0]       o_completed_sb_id;
    logic [CNT_W-1:0] o_inflight_cnt;
    logic             o_credit_err;
    logic             o_track_err;

    int tests = 0;
    int fails = 0;

    tt_ovi_issue_ctrl #(
        .CREDITS (16),
        .INFLIGHT(8),
        .SBID_W  (5)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_issue_valid    (i_issue_valid),
        .o_issue_credit   (o_issue_credit),
        .i_inq_pop        (i_inq_pop),
        .i_inq_sb_id      (i_inq_sb_id),
        .o_inq_pop_en     (o_inq_pop_en),
        .i_commit_valid   (i_commit_valid),
        .o_completed_valid(o_completed_valid),
        .o_completed_sb_id(o_completed_sb_id),
        .o_inflight_cnt   (o_inflight_cnt),
        .o_credit_err     (o_credit_err),
        .o_track_err      (o_track_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic hold_reset;
        i_reset        = 1'b1;
        i_issue_valid  = 1'b0;
        i_inq_pop      = 1'b0;
        i_inq_sb_id    = '0;
        i_commit_valid = 1'b0;
        tick();
        tick();
    endtask

    // Reset and let the 16 initial credits go out.
    task automatic init_run;
        hold_reset();
        i_reset = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset;
        hold_reset();
        tests++;
        if (o_issue_credit !== 1'b0 || o_completed_valid !== 1'b0 || o_completed_sb_id !== 5'd0 ||
            o_inflight_cnt !== 4'd0 || o_credit_err !== 1'b0 || o_track_err !== 1'b0 ||
            o_inq_pop_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: got cr=%0d cv=%0d sb=%0d cnt=%0d ce=%0d te=%0d en=%0d required 0 0 0 0 0 0 1",
                     o_issue_credit, o_completed_valid, o_completed_sb_id, o_inflight_cnt,
                     o_credit_err, o_track_err, o_inq_pop_en);
        end
        i_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (o_issue_credit !== (i < 16)) begin
                fails++;
                $display("FAIL init_credit[%0d]: got %0d required %0d", i, o_issue_credit, (i < 16));
            end
        end
    endtask

    task automatic test_basic;
        logic [4:0] ids [3];
        ids = '{5'd4, 5'd9, 5'd2};
        init_run();
        i_issue_valid = 1'b1;
        repeat (3) tick();
        i_issue_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_inq_pop   = 1'b1;
            i_inq_sb_id = ids[k];
            tick();
            i_inq_pop = 1'b0;
            tests++;
            if (o_inflight_cnt !== 4'(k + 1) || o_issue_credit !== 1'b0) begin
                fails++;
                $display("FAIL basic_pop[%0d]: got cnt=%0d cr=%0d required cnt=%0d cr=0",
                         k, o_inflight_cnt, o_issue_credit, k + 1);
            end
            tick();
            tests++;
            if (o_issue_credit !== 1'b1) begin
                fails++;
                $display("FAIL basic_credit[%0d]: got %0d required 1", k, o_issue_credit);
            end
            tick();
            tests++;
            if (o_issue_credit !== 1'b0) begin
                fails++;
                $display("FAIL basic_credit_end[%0d]: got %0d required 0", k, o_issue_credit);
            end
        end
        for (int k = 0; k < 3; k++) begin
            i_commit_valid = 1'b1;
            tick();
            i_commit_valid = 1'b0;
            tests++;
            if (o_completed_valid !== 1'b1 || o_completed_sb_id !== ids[k]) begin
                fails++;
                $display("FAIL basic_complete[%0d]: got v=%0d id=%0d required v=1 id=%0d",
                         k, o_completed_valid, o_completed_sb_id, ids[k]);
            end
            tick();
            tests++;
            if (o_completed_valid !== 1'b0) begin
                fails++;
                $display("FAIL basic_complete_end[%0d]: got %0d required 0", k, o_completed_valid);
            end
        end
        tests++;
        if (o_inflight_cnt !== 4'd0 || o_track_err !== 1'b0 || o_credit_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_final: got cnt=%0d te=%0d ce=%0d required 0 0 0",
                     o_inflight_cnt, o_track_err, o_credit_err);
        end
    endtask

    task automatic test_full;
        init_run();
        for (int k = 0; k < 8; k++) begin
            i_inq_pop   = 1'b1;
            i_inq_sb_id = 5'(10 + k);
            tick();
            tests++;
            if (o_inflight_cnt !== 4'(k + 1) || o_inq_pop_en !== (k < 7)) begin
                fails++;
                $display("FAIL full_fill[%0d]: got cnt=%0d en=%0d required cnt=%0d en=%0d",
                         k, o_inflight_cnt, o_inq_pop_en, k + 1, (k < 7));
            end
        end
        tests++;
        if (o_track_err !== 1'b0) begin
            fails++;
            $display("FAIL full_no_err: got %0d required 0", o_track_err);
        end
        i_inq_sb_id = 5'd31;
        tick();
        i_inq_pop = 1'b0;
        tests++;
        if (o_track_err !== 1'b1 || o_inflight_cnt !== 4'd8) begin
            fails++;
            $display("FAIL full_overflow: got te=%0d cnt=%0d required te=1 cnt=8",
                     o_track_err, o_inflight_cnt);
        end
        i_commit_valid = 1'b1;
        #1;
        tests++;
        if (o_inq_pop_en !== 1'b0) begin
            fails++;
            $display("FAIL full_same_cycle_en: got %0d required 0", o_inq_pop_en);
        end
        tick();
        i_commit_valid = 1'b0;
        tests++;
        if (o_completed_valid !== 1'b1 || o_completed_sb_id !== 5'd10 ||
            o_inflight_cnt !== 4'd7 || o_inq_pop_en !== 1'b1) begin
            fails++;
            $display("FAIL full_commit: got v=%0d id=%0d cnt=%0d en=%0d required 1 10 7 1",
                     o_completed_valid, o_completed_sb_id, o_inflight_cnt, o_inq_pop_en);
        end
        // Drain: the dropped id 31 must never appear.
        for (int k = 1; k < 8; k++) begin
            i_commit_valid = 1'b1;
            tick();
            tests++;
            if (o_completed_sb_id !== 5'(10 + k)) begin
                fails++;
                $display("FAIL full_drain[%0d]: got %0d required %0d", k, o_completed_sb_id, 10 + k);
            end
        end
        i_commit_valid = 1'b0;
    endtask

    task automatic test_init_pop;
        hold_reset();
        i_reset = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            i_inq_pop   = (i == 5);
            i_inq_sb_id = 5'd3;
            tick();
            tests++;
            if (o_issue_credit !== (i <= 17)) begin
                fails++;
                $display("FAIL init_pop_credit[%0d]: got %0d required %0d", i, o_issue_credit, (i <= 17));
            end
        end
        i_inq_pop = 1'b0;
    endtask

    task automatic test_empty_commit;
        init_run();
        i_commit_valid = 1'b1;
        i_inq_pop      = 1'b1;
        i_inq_sb_id    = 5'd7;
        tick();
        i_commit_valid = 1'b0;
        i_inq_pop      = 1'b0;
        tests++;
        if (o_completed_valid !== 1'b0 || o_track_err !== 1'b1 || o_inflight_cnt !== 4'd1) begin
            fails++;
            $display("FAIL empty_commit: got v=%0d te=%0d cnt=%0d required 0 1 1",
                     o_completed_valid, o_track_err, o_inflight_cnt);
        end
        i_commit_valid = 1'b1;
        tick();
        i_commit_valid = 1'b0;
        tests++;
        if (o_completed_valid !== 1'b1 || o_completed_sb_id !== 5'd7) begin
            fails++;
            $display("FAIL empty_then_commit: got v=%0d id=%0d required 1 7",
                     o_completed_valid, o_completed_sb_id);
        end
    endtask

    task automatic test_credit_err;
        // Core holds 16 after init: 16 issues are legal, the 17th is not.
        init_run();
        i_issue_valid = 1'b1;
        repeat (16) tick();
        tests++;
        if (o_credit_err !== 1'b0) begin
            fails++;
            $display("FAIL credit_16_ok: got %0d required 0", o_credit_err);
        end
        tick();
        i_issue_valid = 1'b0;
        tests++;
        if (o_credit_err !== 1'b1) begin
            fails++;
            $display("FAIL credit_17_err: got %0d required 1", o_credit_err);
        end
        // Issue on first cycle after reset: nothing held, no pulse yet.
        hold_reset();
        i_reset       = 1'b0;
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        tests++;
        if (o_credit_err !== 1'b1) begin
            fails++;
            $display("FAIL credit_zero_err: got %0d required 1", o_credit_err);
        end
        // Issue while the first pulse is visible: the pulse covers it.
        hold_reset();
        i_reset = 1'b0;
        tick();
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        tests++;
        if (o_credit_err !== 1'b0) begin
            fails++;
            $display("FAIL credit_same_cycle: got %0d required 0", o_credit_err);
        end
    endtask

    task automatic test_wrap;
        int exp_id;
        int push_id;
        init_run();
        exp_id  = 1;
        push_id = 1;
        for (int c = 0; c < 23; c++) begin
            i_inq_pop      = (c < 20);
            i_inq_sb_id    = 5'(push_id);
            i_commit_valid = (c >= 3);
            tick();
            if (c < 20) push_id++;
            tests++;
            if (o_inflight_cnt !== 4'((c < 3) ? c + 1 : (c < 20) ? 3 : 22 - c)) begin
                fails++;
                $display("FAIL wrap_cnt[%0d]: got %0d required %0d", c, o_inflight_cnt,
                         (c < 3) ? c + 1 : (c < 20) ? 3 : 22 - c);
            end
            if (c >= 3) begin
                tests++;
                if (o_completed_valid !== 1'b1 || o_completed_sb_id !== 5'(exp_id)) begin
                    fails++;
                    $display("FAIL wrap_order[%0d]: got v=%0d id=%0d required v=1 id=%0d",
                             c, o_completed_valid, o_completed_sb_id, exp_id);
                end
                exp_id++;
            end
        end
        i_inq_pop      = 1'b0;
        i_commit_valid = 1'b0;
        tests++;
        if (o_track_err !== 1'b0) begin
            fails++;
            $display("FAIL wrap_err: got %0d required 0", o_track_err);
        end
    endtask

    task automatic test_mid_reset;
        init_run();
        i_inq_pop   = 1'b1;
        i_inq_sb_id = 5'd5;
        repeat (9) tick();
        i_inq_pop = 1'b0;
        i_reset   = 1'b1;
        tick();
        tests++;
        if (o_inflight_cnt !== 4'd0 || o_track_err !== 1'b0 || o_issue_credit !== 1'b0 ||
            o_inq_pop_en !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: got cnt=%0d te=%0d cr=%0d en=%0d required 0 0 0 1",
                     o_inflight_cnt, o_track_err, o_issue_credit, o_inq_pop_en);
        end
        i_reset = 1'b0;
        tick();
        tests++;
        if (o_issue_credit !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_restart: got %0d required 1", o_issue_credit);
        end
    endtask

    initial begin
        i_reset        = 1'b1;
        i_issue_valid  = 1'b0;
        i_inq_pop      = 1'b0;
        i_inq_sb_id    = '0;
        i_commit_valid = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_init_pop();
        test_empty_commit();
        test_credit_err();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
